// File: rtl/io_port_arbiter.sv
// io_port_arbiter: serialises single-beat read/write transactions from the CPU
// and the DMA engine onto the shared 4-port I/O module. Each transaction takes
// four cycles: IDLE (sample/grant), ACCESS (io_we), WAIT (capture io_rdata), and
// ACK (one-cycle pulse to the owner).
module io_port_arbiter #(
    parameter int   DATA_W   = 8,
    parameter logic CPU_PRIO = 1'b0   // 0: alternate on ties, 1: CPU always wins ties
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_port,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [1:0]        dma_port,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,

    output logic              io_we,
    output logic [1:0]        io_sel_port,
    output logic [DATA_W-1:0] io_wdata,
    input  logic [DATA_W-1:0] io_rdata,

    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    state_t              state_q, state_d;

    // io_sel_port_q / io_wdata_q double as the latched transaction fields:
    // they are loaded on the grant edge and held until the next grant, which
    // keeps the port mux stable while idle.
    logic                io_we_q;
    logic [1:0]          io_sel_port_q;
    logic [DATA_W-1:0]   io_wdata_q;
    logic                owner_q;
    logic                cpu_ack_q, dma_ack_q;
    logic [DATA_W-1:0]   cpu_rdata_q, dma_rdata_q;

    logic                grant_dma;
    logic                load;
    logic                capture;
    logic                win_we;
    logic [1:0]          win_port;
    logic [DATA_W-1:0]   win_wdata;

    // Winner selection: a lone requester always wins; on a tie either the CPU
    // wins outright or the requester that did not own the last grant wins.
    always_comb begin
        grant_dma = 1'b0;
        if (cpu_req && dma_req) begin
            grant_dma = CPU_PRIO ? 1'b0 : ~owner_q;
        end else begin
            grant_dma = dma_req;
        end
        win_we    = grant_dma ? dma_we    : cpu_we;
        win_port  = grant_dma ? dma_port  : cpu_port;
        win_wdata = grant_dma ? dma_wdata : cpu_wdata;
    end

    // Next-state logic; requests are only looked at while idle.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cpu_req || dma_req) begin
                    load    = 1'b1;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: state_d = S_WAIT;
            S_WAIT: begin
                capture = 1'b1;
                state_d = S_ACK;
            end
            S_ACK:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant latch, write strobe, read-data capture and ack pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            io_we_q       <= 1'b0;
            io_sel_port_q <= 2'd0;
            io_wdata_q    <= '0;
            owner_q       <= 1'b1;   // CPU wins the first tie
            cpu_ack_q     <= 1'b0;
            dma_ack_q     <= 1'b0;
            cpu_rdata_q   <= '0;
            dma_rdata_q   <= '0;
        end else begin
            // io_we is only ever high in ACCESS, the cycle right after grant.
            io_we_q   <= load & win_we;
            // Acks land in ACK, the cycle after capture; only the owner's fires.
            cpu_ack_q <= capture & ~owner_q;
            dma_ack_q <= capture &  owner_q;
            if (load) begin
                io_sel_port_q <= win_port;
                io_wdata_q    <= win_wdata;
                owner_q       <= grant_dma;
            end
            // Capture on both reads and writes; io_rdata is valid one cycle
            // after sel_port changed, i.e. during WAIT.
            if (capture) begin
                if (owner_q) begin
                    dma_rdata_q <= io_rdata;
                end else begin
                    cpu_rdata_q <= io_rdata;
                end
            end
        end
    end

    assign io_we       = io_we_q;
    assign io_sel_port = io_sel_port_q;
    assign io_wdata    = io_wdata_q;
    assign cpu_ack     = cpu_ack_q;
    assign dma_ack     = dma_ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign dma_rdata   = dma_rdata_q;
    assign owner       = owner_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_io_port_arbiter.sv
// Bench for io_port_arbiter: a round-robin instance and a CPU-priority
// instance share one stimulus; each has a small registered I/O port model.
module tb_io_port_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, dma_req, dma_we;
    logic [1:0] cpu_port, dma_port;
    logic [7:0] cpu_wdata, dma_wdata;

    logic       cack0, dack0, iowe0, busy0, own0;
    logic [1:0] sel0;
    logic [7:0] iowd0, crd0, drd0, iord0;
    logic       cack1, dack1, iowe1, busy1, own1;
    logic [1:0] sel1;
    logic [7:0] iowd1, crd1, drd1, iord1;

    logic [7:0] in_p [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    initial begin
        in_p[0] = 8'h11; in_p[1] = 8'h3C; in_p[2] = 8'h5A; in_p[3] = 8'h77;
    end

    // io_module read path: registered mux of the port inputs.
    always @(posedge clk) begin
        iord0 <= in_p[sel0];
        iord1 <= in_p[sel1];
    end

    io_port_arbiter #(.DATA_W(8), .CPU_PRIO(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_port(cpu_port), .cpu_wdata(cpu_wdata),
        .cpu_ack(cack0), .cpu_rdata(crd0),
        .dma_req(dma_req), .dma_we(dma_we), .dma_port(dma_port), .dma_wdata(dma_wdata),
        .dma_ack(dack0), .dma_rdata(drd0),
        .io_we(iowe0), .io_sel_port(sel0), .io_wdata(iowd0), .io_rdata(iord0),
        .busy(busy0), .owner(own0)
    );

    io_port_arbiter #(.DATA_W(8), .CPU_PRIO(1'b1)) dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_port(cpu_port), .cpu_wdata(cpu_wdata),
        .cpu_ack(cack1), .cpu_rdata(crd1),
        .dma_req(dma_req), .dma_we(dma_we), .dma_port(dma_port), .dma_wdata(dma_wdata),
        .dma_ack(dack1), .dma_rdata(drd1),
        .io_we(iowe1), .io_sel_port(sel1), .io_wdata(iowd1), .io_rdata(iord1),
        .busy(busy1), .owner(own1)
    );

    typedef struct {
        logic       rst;
        logic       creq, cwe;
        logic [1:0] cport;
        logic [7:0] cwd;
        logic       dreq, dwe;
        logic [1:0] dport;
        logic [7:0] dwd;
        logic       cack, dack, iowe;
        logic [1:0] sel;
        logic [7:0] iowd;
        logic       busy, own;
        logic [7:0] crd, drd;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic creq, input logic cwe,
                         input logic [1:0] cport, input logic [7:0] cwd,
                         input logic dreq, input logic dwe,
                         input logic [1:0] dport, input logic [7:0] dwd);
        reset = rst;
        cpu_req = creq; cpu_we = cwe; cpu_port = cport; cpu_wdata = cwd;
        dma_req = dreq; dma_we = dwe; dma_port = dport; dma_wdata = dwd;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        chk("ack_exclusive0", {31'd0, cack0 & dack0}, 32'd0);
    endtask

    initial begin
        drive(1'b1, 0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00);

        // Each row: inputs before an edge, then outputs expected after it.
        //           rst  creq cwe cport cwd    dreq dwe dport dwd    cack dack iowe sel  iowd   busy own crd    drd
        vecs[0] = '{1'b1, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,1'b0,2'd0,8'h00, 1'b0,1'b1,8'h00,8'h00};
        // CPU write port 2 / 0xA5
        vecs[1] = '{1'b0, 1'b1,1'b1,2'd2,8'hA5, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,1'b1,2'd2,8'hA5, 1'b1,1'b0,8'h00,8'h00};
        // fields disturbed mid-transaction: latched values must hold
        vecs[2] = '{1'b0, 1'b1,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,1'b0,2'd2,8'hA5, 1'b1,1'b0,8'h00,8'h00};
        vecs[3] = '{1'b0, 1'b1,1'b1,2'd2,8'hA5, 1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,1'b0,2'd2,8'hA5, 1'b1,1'b0,8'h5A,8'h00};
        vecs[4] = '{1'b0, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,1'b0,2'd2,8'hA5, 1'b0,1'b0,8'h5A,8'h00};
        // DMA read port 1
        vecs[5] = '{1'b0, 1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,2'd1,8'hFF, 1'b0,1'b0,1'b0,2'd1,8'hFF, 1'b1,1'b1,8'h5A,8'h00};
        vecs[6] = '{1'b0, 1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,2'd1,8'hFF, 1'b0,1'b0,1'b0,2'd1,8'hFF, 1'b1,1'b1,8'h5A,8'h00};
        vecs[7] = '{1'b0, 1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,2'd1,8'hFF, 1'b0,1'b1,1'b0,2'd1,8'hFF, 1'b1,1'b1,8'h5A,8'h3C};
        vecs[8] = '{1'b0, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,1'b0,2'd1,8'hFF, 1'b0,1'b1,8'h5A,8'h3C};
        vecs[9] = '{1'b0, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,1'b0,2'd1,8'hFF, 1'b0,1'b1,8'h5A,8'h3C};

        #2;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rst, vecs[i].creq, vecs[i].cwe, vecs[i].cport, vecs[i].cwd,
                  vecs[i].dreq, vecs[i].dwe, vecs[i].dport, vecs[i].dwd);
            step();
            chk($sformatf("v%0d cpu_ack", i),   {31'd0, cack0}, {31'd0, vecs[i].cack});
            chk($sformatf("v%0d dma_ack", i),   {31'd0, dack0}, {31'd0, vecs[i].dack});
            chk($sformatf("v%0d io_we", i),     {31'd0, iowe0}, {31'd0, vecs[i].iowe});
            chk($sformatf("v%0d io_sel", i),    {30'd0, sel0},  {30'd0, vecs[i].sel});
            chk($sformatf("v%0d io_wdata", i),  {24'd0, iowd0}, {24'd0, vecs[i].iowd});
            chk($sformatf("v%0d busy", i),      {31'd0, busy0}, {31'd0, vecs[i].busy});
            chk($sformatf("v%0d owner", i),     {31'd0, own0},  {31'd0, vecs[i].own});
            chk($sformatf("v%0d cpu_rdata", i), {24'd0, crd0},  {24'd0, vecs[i].crd});
            chk($sformatf("v%0d dma_rdata", i), {24'd0, drd0},  {24'd0, vecs[i].drd});
            chk($sformatf("v%0d p1 cpu_ack", i), {31'd0, cack1}, {31'd0, vecs[i].cack});
            chk($sformatf("v%0d p1 dma_ack", i), {31'd0, dack1}, {31'd0, vecs[i].dack});
        end

        // Continuous simultaneous reads: CPU port 0 (0x11), DMA port 3 (0x77).
        drive(1'b1, 0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00);
        step();
        drive(1'b0, 1, 0, 2'd0, 8'h00, 1, 0, 2'd3, 8'h00);
        for (int k = 1; k <= 16; k++) begin
            logic ack_slot;
            logic cpu_turn;
            step();
            ack_slot = (k % 4 == 3);
            cpu_turn = ((k / 4) % 2 == 0);
            chk($sformatf("rr k%0d cpu_ack", k), {31'd0, cack0}, {31'd0, ack_slot & cpu_turn});
            chk($sformatf("rr k%0d dma_ack", k), {31'd0, dack0}, {31'd0, ack_slot & ~cpu_turn});
            chk($sformatf("pr k%0d cpu_ack", k), {31'd0, cack1}, {31'd0, ack_slot});
            chk($sformatf("pr k%0d dma_ack", k), {31'd0, dack1}, 32'd0);
            if (ack_slot && cpu_turn) chk($sformatf("rr k%0d cpu_rdata", k), {24'd0, crd0}, 32'h11);
            if (ack_slot && !cpu_turn) chk($sformatf("rr k%0d dma_rdata", k), {24'd0, drd0}, 32'h77);
            if (ack_slot) chk($sformatf("pr k%0d cpu_rdata", k), {24'd0, crd1}, 32'h11);
        end

        // Reset during ACCESS of a CPU read of port 3.
        drive(1'b1, 0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00);
        step();
        drive(1'b0, 1, 0, 2'd3, 8'h00, 0, 0, 2'd0, 8'h00);
        step();
        chk("abort access busy", {31'd0, busy0}, 32'd1);
        chk("abort access sel",  {30'd0, sel0},  32'd3);
        drive(1'b1, 0, 0, 2'd3, 8'h00, 0, 0, 2'd0, 8'h00);
        step();
        chk("abort busy",  {31'd0, busy0}, 32'd0);
        chk("abort io_we", {31'd0, iowe0}, 32'd0);
        chk("abort sel",   {30'd0, sel0},  32'd0);
        chk("abort owner", {31'd0, own0},  32'd1);
        drive(1'b0, 0, 0, 2'd3, 8'h00, 0, 0, 2'd0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("abort quiet k%0d ack", k), {31'd0, cack0 | iowe0 | busy0}, 32'd0);
        end
        drive(1'b0, 1, 0, 2'd3, 8'h00, 0, 0, 2'd0, 8'h00);
        step(); step();
        chk("rereq before ack", {31'd0, cack0}, 32'd0);
        step();
        chk("rereq cpu_ack",   {31'd0, cack0}, 32'd1);
        chk("rereq cpu_rdata", {24'd0, crd0},  32'h77);
        drive(1'b0, 0, 0, 2'd3, 8'h00, 0, 0, 2'd0, 8'h00);
        step();

        // DMA write request arriving while a CPU read of port 2 is in WAIT.
        drive(1'b1, 0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00);
        step();
        drive(1'b0, 1, 0, 2'd2, 8'h00, 0, 0, 2'd0, 8'h00);
        step();                                   // ACCESS
        step();                                   // WAIT
        drive(1'b0, 1, 0, 2'd2, 8'h00, 1, 1, 2'd1, 8'h42);
        step();                                   // ACK
        chk("late cpu_ack",   {31'd0, cack0}, 32'd1);
        chk("late dma_ack",   {31'd0, dack0}, 32'd0);
        chk("late cpu_rdata", {24'd0, crd0},  32'h5A);
        drive(1'b0, 0, 0, 2'd2, 8'h00, 1, 1, 2'd1, 8'h42);
        step();                                   // IDLE
        chk("late idle busy", {31'd0, busy0}, 32'd0);
        step();                                   // DMA ACCESS
        chk("late dma io_we", {31'd0, iowe0}, 32'd1);
        chk("late dma sel",   {30'd0, sel0},  32'd1);
        chk("late dma wdata", {24'd0, iowd0}, 32'h42);
        chk("late dma owner", {31'd0, own0},  32'd1);
        step();
        chk("late dma io_we off", {31'd0, iowe0}, 32'd0);
        step();
        chk("late dma_ack", {31'd0, dack0}, 32'd1);
        chk("late dma cpu_ack", {31'd0, cack0}, 32'd0);
        drive(1'b0, 0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_port_arbiter.md
Name: io_port_arbiter

Overview:
Arbitrates access to the shared 4-port I/O module between two requesters: the CPU datapath and a DMA/polling engine. It serialises single-beat read/write transactions and drives the I/O module's we, sel_port and write-data inputs. It captures the port read data and returns it to the winning requester with a one-cycle ack. It sits between the CPU core, the DMA engine and io_module.

Parameters:
DATA_W, 8, port data width (matches I/O ports).
CPU_PRIO, 0, 0 = round-robin between requesters; 1 = fixed priority to CPU.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
cpu_req  input  1  CPU transaction request; held until cpu_ack.
cpu_we  input  1  1 = write, 0 = read.
cpu_port  input  2  target port 0-3.
cpu_wdata  input  DATA_W  write data.
cpu_ack  output  1  one-cycle completion pulse.
cpu_rdata  output  DATA_W  read data, valid while cpu_ack = 1, held afterwards.
dma_req, dma_we, dma_port, dma_wdata, dma_ack, dma_rdata: same as the cpu_* ports, for the DMA requester.
io_we  output  1  to io_module we.
io_sel_port  output  2  to io_module sel_port.
io_wdata  output  DATA_W  to io_module in_RD2.
io_rdata  input  DATA_W  from io_module data_in_from_port (registered inside io_module, valid one cycle after sel_port changes).
busy  output  1  1 when state != IDLE.
owner  output  1  current/last grant: 0 = CPU, 1 = DMA.

Behaviour:
- Reset state: state = IDLE; cpu_ack = dma_ack = 0; cpu_rdata = dma_rdata = 0; io_we = 0; io_sel_port = 0; io_wdata = 0; busy = 0; owner = 1. owner = 1 makes the CPU win the first tie.
- FSM states and transitions:
  - IDLE: the only state in which requests are sampled.
    - No request: stay in IDLE.
    - Request(s) present: choose a winner; latch its we, port and wdata into internal registers; set owner; go to ACCESS.
  - ACCESS (1 cycle):
    - io_sel_port = latched port; io_wdata = latched wdata.
    - io_we = latched we. io_we is high only in this cycle, and only for writes.
    - Go to WAIT.
  - WAIT (1 cycle): io_sel_port held. At the end of the cycle, capture io_rdata into the owner's rdata register for both reads and writes. Go to ACK.
  - ACK (1 cycle): the owner's ack = 1; the other requester's ack = 0. Go to IDLE.
- Latency: request sampled in IDLE at cycle N; io_we in cycle N+1; ack in cycle N+3. Maximum throughput is one transaction per 4 cycles.
- Requester rule: keep req and its fields stable from assertion until ack.
  - If req is still high in the IDLE cycle after ack, it is treated as a new transaction.
- Arbitration:
  - CPU_PRIO = 0: only one requester → it wins. Both requesting → the requester that is not owner wins (strict alternation).
  - CPU_PRIO = 1: CPU always wins a tie; DMA may starve (intended).
- Outputs while idle:
  - io_sel_port and io_wdata hold their last values, so the port mux stays stable.
  - io_we = 0.
  - rdata registers hold their last captured values.
- A request that arrives mid-transaction (state != IDLE) is not lost; it is sampled at the next IDLE cycle.
- Changing the latched fields during ACCESS/WAIT/ACK has no effect, because the fields are latched in IDLE.
- Reset mid-transaction:
  - Next cycle is IDLE with all outputs at reset values.
  - No ack is issued and no io_we is pulsed afterwards.
  - An aborted write is lost if reset hits before ACCESS; the requester must re-request.
- Never more than one ack per cycle; cpu_ack and dma_ack are never high together.

Test Plan:
- CPU write: cpu_req = 1, we = 1, port = 2, wdata = 0xA5 → io_we = 1 for exactly 1 cycle (N+1) with io_sel_port = 2, io_wdata = 0xA5; cpu_ack = 1 at N+3 only; dma_ack stays 0.
- DMA read: in_p1 = 0x3C, dma_req = 1, we = 0, port = 1 → io_we stays 0; dma_rdata = 0x3C with dma_ack at N+3; owner = 1.
- Simultaneous continuous requests after reset, CPU_PRIO = 0 → grant order CPU, DMA, CPU, DMA; acks 4 cycles apart, alternating.
- Same stimulus with CPU_PRIO = 1 → only cpu_ack pulses (every 4 cycles); dma_ack never asserts.
- Reset asserted during ACCESS of a CPU read → next cycle IDLE, busy = 0, io_we = 0, io_sel_port = 0, no cpu_ack; a re-request completes normally.
- DMA request arriving while a CPU transaction is in WAIT → DMA is granted in the IDLE cycle after cpu_ack; dma_ack 4 cycles later.
